// File: rtl/lock_pkg.sv
// Shared constants and types for the lock-in filter blocks.
package lock_pkg;

   // Width of the low-pass estimate accumulator
   localparam int LP_ACC_W      = 49;
   // Number of cycles the high-pass output stays muted after a preload
   localparam int HP_SETTLE_LEN = 64;
   localparam int HP_CNT_W      = $clog2(HP_SETTLE_LEN);

   typedef enum logic [1:0] {
      PRELOAD = 2'd0,
      SETTLE  = 2'd1,
      RUN     = 2'd2,
      HOLD    = 2'd3
   } hp_state_t;

   // Any non-zero value in the upper tau bits selects pass-through.
   function automatic logic tau_is_bypass(input logic [5:0] t);
      return (t[5:4] != 2'b00);
   endfunction

endpackage

// File: rtl/sat_trunc.sv
// Generic signed saturating narrow from IW bits down to OW bits.
module sat_trunc #(
   parameter int IW = 50,
   parameter int OW = 49
) (
   input  logic signed [IW-1:0] din,
   output logic signed [OW-1:0] dout
);

   localparam logic signed [OW-1:0] MAXV = {1'b0, {(OW-1){1'b1}}};
   localparam logic signed [OW-1:0] MINV = {1'b1, {(OW-1){1'b0}}};

   logic fits;

   // Value fits when every dropped bit agrees with the new sign bit;
   // otherwise clamp toward the sign of the wide input.
   always_comb begin
      fits = (din[IW-1:OW-1] == {(IW-OW+1){din[IW-1]}});
      if (fits)
         dout = din[OW-1:0];
      else if (din[IW-1])
         dout = MINV;
      else
         dout = MAXV;
   end

endmodule

// File: rtl/hp_filter2.sv
// First-order DC-removal filter: out = in - lowpass(in), with preload,
// settle-window muting, freeze and bypass handled by a small FSM.
module hp_filter2
   import lock_pkg::*;
#(
   parameter int R = 14
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [5:0]          tau,
   input  logic                hold,
   input  logic signed [R-1:0] in,
   output logic signed [R-1:0] out,
   output logic                settled
);

   localparam int S = LP_ACC_W;

   hp_state_t             state_reg, state_next;
   logic [HP_CNT_W-1:0]   cnt_reg, cnt_next;
   logic [5:0]            tau_q;
   logic signed [S-1:0]   sum_reg, sum_next;
   logic signed [R-1:0]   out_next;
   logic                  settled_next;

   logic signed [R-1:0]   lp;
   logic signed [S:0]     acc_wide;
   logic signed [S-1:0]   acc_sat;
   logic signed [R:0]     hp_wide;
   logic signed [R-1:0]   hp_sat;
   logic signed [S-1:0]   preload_val;
   logic [4:0]            preload_shamt;
   logic                  tau_changed;

   // Datapath: low-pass estimate, accumulator update, high-pass value and
   // the preload that makes lp equal the current input exactly.
   always_comb begin
      lp            = R'((sum_reg >>> 6) >>> tau[3:0]);
      acc_wide      = {sum_reg[S-1], sum_reg}
                      + {{(S+1-R){in[R-1]}}, in}
                      - {{(S+1-R){lp[R-1]}}, lp};
      hp_wide       = {in[R-1], in} - {lp[R-1], lp};
      preload_shamt = 5'd6 + {1'b0, tau[3:0]};
      preload_val   = {{(S-R){in[R-1]}}, in} << preload_shamt;
      tau_changed   = (tau != tau_q);
   end

   sat_trunc #(.IW(S+1), .OW(S)) u_acc_sat (
      .din  (acc_wide),
      .dout (acc_sat)
   );

   sat_trunc #(.IW(R+1), .OW(R)) u_out_sat (
      .din  (hp_wide),
      .dout (hp_sat)
   );

   // Next-state, accumulator and output selection. A tau change overrides
   // everything (including hold and end of settle) and mutes the output on
   // the edge that enters PRELOAD; bypass overrides only the outputs.
   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      sum_next     = sum_reg;
      out_next     = '0;
      settled_next = 1'b0;

      case (state_reg)
         PRELOAD: begin
            sum_next   = preload_val;
            cnt_next   = '0;
            state_next = SETTLE;
         end
         SETTLE: begin
            sum_next = acc_sat;
            cnt_next = cnt_reg + 1'b1;
            if (cnt_reg == HP_CNT_W'(HP_SETTLE_LEN - 1))
               state_next = RUN;
         end
         RUN: begin
            sum_next = acc_sat;
            out_next = hp_sat;
            if (hold)
               state_next = HOLD;
         end
         HOLD: begin
            out_next = hp_sat;
            if (!hold)
               state_next = RUN;
         end
         default: begin
            state_next = PRELOAD;
         end
      endcase

      if (tau_changed) begin
         state_next = PRELOAD;
         cnt_next   = '0;
         out_next   = '0;
      end

      settled_next = (state_next == RUN) || (state_next == HOLD);

      if (tau_is_bypass(tau)) begin
         out_next     = in;
         settled_next = 1'b1;
      end
   end

   // State, accumulator and registered outputs; reset clears all at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= PRELOAD;
         cnt_reg   <= '0;
         tau_q     <= '0;
         sum_reg   <= '0;
         out       <= '0;
         settled   <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         tau_q     <= tau;
         sum_reg   <= sum_next;
         out       <= out_next;
         settled   <= settled_next;
      end
   end

endmodule

// File: tb/tb_hp_filter2.sv
// Directed self-checking bench for hp_filter2 (R = 14).
module tb_hp_filter2;

   localparam int R = 14;

   logic                clk;
   logic                rst;
   logic [5:0]          tau;
   logic                hold;
   logic signed [R-1:0] din;
   logic signed [R-1:0] out;
   logic                settled;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [5:0]          tau;
      logic signed [R-1:0] din;
      logic signed [R-1:0] exp_out;
   } vec_t;

   vec_t vecs[8];

   hp_filter2 #(.R(R)) dut (
      .clk     (clk),
      .rst     (rst),
      .tau     (tau),
      .hold    (hold),
      .in      (din),
      .out     (out),
      .settled (settled)
   );

   initial clk = 1'b0;
   always #4 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      n_cmp++;
      if (act < lo || act > hi) begin
         n_bad++;
         $display("FAIL %s: got %0d expected in [%0d,%0d]", name, act, lo, hi);
      end
   endtask

   initial begin
      int prev;

      // Bypass vectors: output is the input delayed by one cycle.
      vecs[0] = '{6'h10,  14'sd123,   14'sd123};
      vecs[1] = '{6'h10, -14'sd5000, -14'sd5000};
      vecs[2] = '{6'h10,  14'sd8191,  14'sd8191};
      vecs[3] = '{6'h10, -14'sd8192, -14'sd8192};
      vecs[4] = '{6'h2F,  14'sd0,     14'sd0};
      vecs[5] = '{6'h25,  14'sd77,    14'sd77};
      vecs[6] = '{6'h30, -14'sd1,    -14'sd1};
      vecs[7] = '{6'h10,  14'sd4000,  14'sd4000};

      // Reset and DC rejection
      rst  = 1'b1;
      tau  = 6'd0;
      hold = 1'b0;
      din  = 14'sd1000;
      repeat (3) @(negedge clk);
      check("rst_out", out, 0);
      check("rst_settled", settled, 0);
      rst = 1'b0;
      for (int e = 1; e <= 70; e++) begin
         tick();
         check("dc_out", out, 0);
         check("dc_settled", settled, (e >= 65) ? 1 : 0);
      end
      $display("reset/dc phase done: out=%0d settled=%0d", out, settled);

      // tau change 0 -> 3 with constant input
      tau = 6'd3;
      for (int e = 1; e <= 70; e++) begin
         tick();
         check("tau_out", out, 0);
         check("tau_settled", settled, (e >= 66) ? 1 : 0);
      end
      $display("tau change phase done: out=%0d settled=%0d", out, settled);

      // Step response with tau = 0
      tau = 6'd0;
      din = 14'sd0;
      repeat (70) tick();
      check("step_pre_settled", settled, 1);
      din = 14'sd4096;
      tick();
      check("step_first", out, 4096);
      prev = int'(out);
      for (int j = 2; j <= 701; j++) begin
         tick();
         check_range("step_mono", out, 0, prev);
         prev = int'(out);
         if (j == 65)  check_range("step_tau", out, 1476, 1537);
         if (j == 701) check_range("step_final", out, 0, 1);
      end
      $display("step phase done: out=%0d", out);

      // Hold: freeze first, then step the input by +500
      hold = 1'b1;
      tick();
      check("hold_entry", out, 0);
      din = 14'sd4596;
      for (int k = 0; k < 100; k++) begin
         tick();
         check("hold_out", out, 500);
         check("hold_settled", settled, 1);
      end
      hold = 1'b0;
      tick();
      check("release_0", out, 500);
      tick();
      check("release_1", out, 500);
      tick();
      check("release_2", out, 493);
      repeat (63) tick();
      check_range("release_tau", out, 175, 192);
      $display("hold phase done: out=%0d", out);

      // Asynchronous reset mid-operation, then positive clamp
      din = -14'sd8192;
      #2 rst = 1'b1;
      #1;
      check("async_rst_out", out, 0);
      check("async_rst_settled", settled, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (70) tick();
      din = 14'sd8191;
      tick();
      check("sat_pos", out, 8191);
      tick();
      check("sat_pos_2", out, 8191);

      // Negative clamp
      rst = 1'b1;
      din = 14'sd8191;
      @(negedge clk);
      rst = 1'b0;
      repeat (70) tick();
      din = -14'sd8192;
      tick();
      check("sat_neg", out, -8192);
      $display("saturation phase done: out=%0d", out);

      // Bypass table
      for (int i = 0; i < 8; i++) begin
         tau = vecs[i].tau;
         din = vecs[i].din;
         tick();
         check("bypass_out", out, vecs[i].exp_out);
         check("bypass_settled", settled, 1);
         $display("bypass vec %0d: tau=%h in=%0d out=%0d settled=%0d",
                  i, vecs[i].tau, vecs[i].din, out, settled);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
